// File: rtl/uart_tx_scheduler.sv
// Two-requester byte scheduler in front of a UART CSR bank. It programs the baud divisor
// after reset, then forwards one byte at a time and waits for tx_done or a timeout.
module uart_tx_scheduler #(
   parameter logic [3:0]  csr_addr = 4'h0,
   parameter int unsigned clk_freq = 100000000,
   parameter int unsigned baud     = 38400,
   parameter int unsigned timeout  = 65535
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        req0_valid,
   input  logic [7:0]  req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [7:0]  req1_data,
   output logic        req1_ready,
   output logic [13:0] csr_a,
   output logic        csr_we,
   output logic [31:0] csr_di,
   input  logic        tx_done,
   output logic        busy,
   output logic        timeout_err
);

   localparam logic [15:0] DIVISOR = 16'(clk_freq / baud / 16);
   localparam logic [15:0] TO_LAST = 16'(timeout - 1);

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_IDLE  = 2'd1,
      S_WRITE = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        id_q, id_d;
   logic [7:0]  byte_q, byte_d;
   logic [15:0] cnt_q, cnt_d;
   logic        err_q, err_d;

   logic        gnt0_s, gnt1_s;
   logic        we_s;
   logic [13:0] a_s;
   logic [31:0] di_s;

   // Next-state, arbitration and CSR drive decode
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      byte_d  = byte_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      gnt0_s  = 1'b0;
      gnt1_s  = 1'b0;
      we_s    = 1'b0;
      a_s     = 14'd0;
      di_s    = 32'd0;
      case (state_q)
         S_INIT: begin
            we_s    = 1'b1;
            a_s     = {csr_addr, 9'd0, 1'b1};
            di_s    = {16'd0, DIVISOR};
            state_d = S_IDLE;
         end
         S_IDLE: begin
            // On a tie the requester that was not served last goes first.
            if (req0_valid && (!req1_valid || last_q)) begin
               gnt0_s  = 1'b1;
               byte_d  = req0_data;
               id_d    = 1'b0;
               state_d = S_WRITE;
            end else if (req1_valid) begin
               gnt1_s  = 1'b1;
               byte_d  = req1_data;
               id_d    = 1'b1;
               state_d = S_WRITE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            we_s    = 1'b1;
            a_s     = {csr_addr, 10'd0};
            di_s    = {24'd0, byte_q};
            cnt_d   = 16'd0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 16'd1;
            if (tx_done) begin
               last_d  = id_q;
               state_d = S_IDLE;
            end else if (cnt_q == TO_LAST) begin
               last_d  = id_q;
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT;
            end
         end
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   // State register with synchronous active-low reset
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q <= S_INIT;
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         byte_q  <= 8'd0;
         cnt_q   <= 16'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         byte_q  <= byte_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Reset is synchronous, so mask outputs while it is held to keep the bus quiet
   always_comb begin
      req0_ready  = gnt0_s & sys_rst_n;
      req1_ready  = gnt1_s & sys_rst_n;
      csr_we      = we_s & sys_rst_n;
      csr_a       = sys_rst_n ? a_s : 14'd0;
      csr_di      = sys_rst_n ? di_s : 32'd0;
      busy        = (state_q != S_IDLE) || !sys_rst_n;
      timeout_err = err_q;
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: default-parameter instance plus a timeout=8 instance
// sharing clock, reset and request inputs.
module tb_uart_tx_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        r0_v, r1_v, txd;
   logic [7:0]  r0_d, r1_d;

   logic        a_r0, a_r1, a_we, a_busy, a_err;
   logic [13:0] a_a;
   logic [31:0] a_di;
   logic        b_r0, b_r1, b_we, b_busy, b_err;
   logic [13:0] b_a;
   logic [31:0] b_di;

   int n_vec = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   uart_tx_scheduler u_dut (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .req0_valid(r0_v), .req0_data(r0_d), .req0_ready(a_r0),
      .req1_valid(r1_v), .req1_data(r1_d), .req1_ready(a_r1),
      .csr_a(a_a), .csr_we(a_we), .csr_di(a_di),
      .tx_done(txd), .busy(a_busy), .timeout_err(a_err)
   );

   uart_tx_scheduler #(.timeout(8)) u_dut_to (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .req0_valid(r0_v), .req0_data(r0_d), .req0_ready(b_r0),
      .req1_valid(r1_v), .req1_data(r1_d), .req1_ready(b_r1),
      .csr_a(b_a), .csr_we(b_we), .csr_di(b_di),
      .tx_done(txd), .busy(b_busy), .timeout_err(b_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; r0_v = 1'b0; r1_v = 1'b0; txd = 1'b0;
      r0_d = 8'h00; r1_d = 8'h00;

      // reset state, with a request pending
      tick(); tick();
      r0_v = 1'b1;
      #1;
      chk("rst_we",    32'(a_we),   32'd0);
      chk("rst_a",     32'(a_a),    32'd0);
      chk("rst_di",    a_di,        32'd0);
      chk("rst_busy",  32'(a_busy), 32'd1);
      chk("rst_rdy0",  32'(a_r0),   32'd0);
      chk("rst_err",   32'(a_err),  32'd0);
      r0_v = 1'b0;

      // divisor write on release
      rst_n = 1'b1;
      #1;
      chk("init_we",   32'(a_we),   32'd1);
      chk("init_a",    32'(a_a),    32'h0001);
      chk("init_di",   a_di,        32'h00A2);
      chk("init_busy", 32'(a_busy), 32'd1);
      tick();
      chk("idle_we",   32'(a_we),   32'd0);
      chk("idle_busy", 32'(a_busy), 32'd0);

      // single requester 0, byte 0x55
      r0_v = 1'b1; r0_d = 8'h55;
      #1;
      chk("x0_rdy0", 32'(a_r0), 32'd1);
      chk("x0_rdy1", 32'(a_r1), 32'd0);
      tick();
      r0_v = 1'b0; r0_d = 8'hFF;
      #1;
      chk("x0_we",   32'(a_we),   32'd1);
      chk("x0_a",    32'(a_a),    32'h0000);
      chk("x0_di",   a_di,        32'h0055);
      chk("x0_rdy0", 32'(a_r0),   32'd0);
      tick();
      chk("x0_wait_we",   32'(a_we),   32'd0);
      chk("x0_wait_busy", 32'(a_busy), 32'd1);
      r1_v = 1'b1;
      #1;
      chk("x0_wait_rdy1", 32'(a_r1), 32'd0);
      r1_v = 1'b0;
      repeat (9) tick();
      chk("x0_w10_busy", 32'(a_busy), 32'd1);
      txd = 1'b1;
      tick();
      txd = 1'b0;
      chk("x0_done_busy", 32'(a_busy), 32'd0);
      chk("x0_done_err",  32'(a_err),  32'd0);

      // single requester 1, byte 0x3C
      r1_v = 1'b1; r1_d = 8'h3C;
      #1;
      chk("x1_rdy1", 32'(a_r1), 32'd1);
      chk("x1_rdy0", 32'(a_r0), 32'd0);
      tick();
      r1_v = 1'b0;
      #1;
      chk("x1_di", a_di, 32'h003C);
      tick();
      txd = 1'b1;
      tick();
      txd = 1'b0;

      // round robin with both requesters always valid
      r0_v = 1'b1; r0_d = 8'hA0;
      r1_v = 1'b1; r1_d = 8'hB1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_rdy0", 32'(a_r0), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_rdy1", 32'(a_r1), (i % 2 == 1) ? 32'd1 : 32'd0);
         tick();
         chk("rr_we", 32'(a_we), 32'd1);
         chk("rr_di", a_di, (i % 2 == 0) ? 32'h00A0 : 32'h00B1);
         tick();
         txd = 1'b1;
         tick();
         txd = 1'b0;
         chk("rr_busy", 32'(a_busy), 32'd0);
      end
      r0_v = 1'b0; r1_v = 1'b0;

      // stray tx_done in IDLE
      txd = 1'b1;
      tick();
      txd = 1'b0;
      chk("stray_busy", 32'(a_busy), 32'd0);
      chk("stray_we",   32'(a_we),   32'd0);
      r0_v = 1'b1; r1_v = 1'b1;
      #1;
      chk("stray_rdy0", 32'(a_r0), 32'd1);
      tick();
      tick();
      chk("mid_wait_busy", 32'(a_busy), 32'd1);

      // reset in WAIT with requests still present
      rst_n = 1'b0;
      #1;
      chk("rw_rdy0", 32'(a_r0),   32'd0);
      chk("rw_rdy1", 32'(a_r1),   32'd0);
      chk("rw_we",   32'(a_we),   32'd0);
      chk("rw_busy", 32'(a_busy), 32'd1);
      tick();
      chk("rw2_we",  32'(a_we),   32'd0);
      chk("rw2_a",   32'(a_a),    32'd0);
      chk("rw2_rdy0", 32'(a_r0),  32'd0);
      r0_v = 1'b0; r1_v = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("rw_init_we", 32'(a_we), 32'd1);
      chk("rw_init_a",  32'(a_a),  32'h0001);
      chk("rw_init_di", a_di,      32'h00A2);
      tick();
      chk("rw_idle_we",   32'(a_we),   32'd0);
      chk("rw_idle_busy", 32'(a_busy), 32'd0);

      // timeout=8 instance: abort after 8 WAIT cycles
      r0_v = 1'b1; r1_v = 1'b1; r0_d = 8'h11; r1_d = 8'h22;
      #1;
      chk("to_rdy0", 32'(b_r0), 32'd1);
      chk("to_rdy1", 32'(b_r1), 32'd0);
      tick();
      r0_v = 1'b0; r1_v = 1'b0;
      #1;
      chk("to_di", b_di, 32'h0011);
      tick();
      for (int k = 0; k < 8; k++) begin
         chk("to_wait_err",  32'(b_err),  32'd0);
         chk("to_wait_busy", 32'(b_busy), 32'd1);
         tick();
      end
      chk("to_err_pulse", 32'(b_err),  32'd1);
      chk("to_idle_busy", 32'(b_busy), 32'd0);
      tick();
      chk("to_err_clear", 32'(b_err), 32'd0);
      r0_v = 1'b1; r1_v = 1'b1;
      #1;
      chk("to_next_rdy1", 32'(b_r1), 32'd1);
      chk("to_next_rdy0", 32'(b_r0), 32'd0);

      // tx_done coinciding with the last allowed WAIT cycle
      tick();
      r0_v = 1'b0; r1_v = 1'b0;
      #1;
      chk("edge_di", b_di, 32'h0022);
      tick();
      repeat (7) tick();
      chk("edge_w8_busy", 32'(b_busy), 32'd1);
      txd = 1'b1;
      tick();
      txd = 1'b0;
      chk("edge_err",  32'(b_err),  32'd0);
      chk("edge_busy", 32'(b_busy), 32'd0);
      tick();
      chk("edge_err2", 32'(b_err), 32'd0);
      r0_v = 1'b1; r1_v = 1'b1;
      #1;
      chk("edge_next_rdy0", 32'(b_r0), 32'd1);
      chk("edge_next_rdy1", 32'(b_r1), 32'd0);
      r0_v = 1'b0; r1_v = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter csr_addr, default 4'h0: UART CSR bank select, driven on csr_a[13:10].
REQ-002 Parameter clk_freq, default 100000000: system clock frequency in Hz.
REQ-003 Parameter baud, default 38400: line rate; init divisor = clk_freq/baud/16, truncated to 16 bits.
REQ-004 Parameter timeout, default 65535: max WAIT cycles before abort; 1..65535.
REQ-005 sys_clk  in  1  single clock; all state on rising edge.
REQ-006 sys_rst_n  in  1  one clock; reset is synchronous and active-low.
REQ-007 req0_valid / req1_valid  in  1  requester has a byte to send.
REQ-008 req0_data / req1_data  in  8  byte offered by requester.
REQ-009 req0_ready / req1_ready  out  1  byte accepted this cycle (valid & ready).
REQ-010 csr_a  out  14  UART CSR address.
REQ-011 csr_we  out  1  UART CSR write strobe, one cycle per write.
REQ-012 csr_di  out  32  UART CSR write data.
REQ-013 tx_done  in  1  UART transmit-complete pulse (tx_irq).
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 timeout_err  out  1  one-cycle pulse on WAIT abort.

Function
REQ-016 FSM states INIT, IDLE, WRITE, WAIT; shall leave INIT on the first clock after reset release.
REQ-017 INIT: csr_we=1, csr_a={csr_addr,9'd0,1'b1}, csr_di={16'd0,divisor}; next IDLE.
REQ-018 IDLE: csr_we=0; if any valid, exactly one ready driven high combinationally for the winner; next WRITE with winner byte and id latched; else stay IDLE.
REQ-019 Arbitration: single valid wins; both valid -> requester not granted last wins (round-robin).
REQ-020 Ready shall never be high outside IDLE; never both high.
REQ-021 WRITE: one cycle, csr_we=1, csr_a={csr_addr,10'd0}, csr_di={24'd0,latched byte}; next WAIT; clear timeout counter.
REQ-022 Latency: handshake in cycle N -> csr_we in N+1 -> WAIT from N+2.
REQ-023 WAIT: csr_we=0; counter +1 per cycle; tx_done=1 -> IDLE, last-grant pointer := latched id.
REQ-024 WAIT: counter reaching timeout with tx_done=0 -> IDLE, timeout_err=1 for that cycle, last-grant pointer still updated.
REQ-025 tx_done in the same cycle the counter reaches timeout counts as completion; no timeout_err.
REQ-026 tx_done outside WAIT shall be ignored (no state/pointer change).
REQ-027 Requests dropped before handshake are not buffered; latched byte unaffected by later input changes.
REQ-028 Outputs outside active states: csr_a=0, csr_di=0, csr_we=0.

Reset
REQ-029 sys_rst_n=0 at a clock edge -> state INIT, last-grant pointer=1 (req0 wins first tie), counter=0, latched byte/id=0, timeout_err=0.
REQ-030 During reset: csr_we=0, csr_a=0, csr_di=0, ready=0, busy=1.
REQ-031 Reset mid-WRITE or mid-WAIT abandons the byte; no ready pulse or CSR write while reset is low; divisor is re-written in INIT after release.

Verification
REQ-032 Defaults, release reset -> exactly one write: csr_a=0x0001, csr_di=0x00A2 (162); then IDLE, busy=0.
REQ-033 req0_valid=1, data=0x55 in IDLE -> req0_ready same cycle, next cycle csr_we=1, csr_a=0x0000, csr_di=0x55; tx_done 10 cycles later -> IDLE.
REQ-034 Both valid continuously (0xA0/0xB1), tx_done each WAIT -> grants 0,1,0,1; CSR data A0,B1,A0,B1.
REQ-035 timeout=8, no tx_done -> timeout_err single pulse 8 cycles into WAIT, then IDLE; next tie goes to other requester.
REQ-036 tx_done pulsed in IDLE, then reset in WAIT -> no state change for the stray pulse; reset leads to INIT divisor write, no byte write.
